// File: rtl/instr_encoder_if.sv
// Request / IM-write / status bundle between a program source and instr_encoder.
// The source drives the master side. The encoder is the slave side.
// The handshake is valid/ready on requests and we/ready on IM writes.
interface instr_encoder_if #(
   parameter int ADDR_W = 10
);
   // program control
   logic              start;
   logic [ADDR_W-1:0] base;
   logic              seal;
   // request channel
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_kind;
   logic [4:0]        req_rs;
   logic [4:0]        req_rt;
   logic [4:0]        req_rd;
   logic [15:0]       req_imm;
   // IM write channel
   logic              im_we;
   logic              im_ready;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   // status
   logic              busy;
   logic              done;
   logic              wrapped;
   logic              err;

   modport master (
      output start, base, seal,
      output req_valid, req_kind, req_rs, req_rt, req_rd, req_imm,
      output im_ready,
      input  req_ready, im_we, im_addr, im_wdata,
      input  busy, done, wrapped, err
   );

   modport slave (
      input  start, base, seal,
      input  req_valid, req_kind, req_rs, req_rt, req_rd, req_imm,
      input  im_ready,
      output req_ready, im_we, im_addr, im_wdata,
      output busy, done, wrapped, err
   );
endinterface

// File: rtl/instr_encoder.sv
// Purpose: encodes symbolic MIPS requests into 32-bit words and streams them to IM at consecutive addresses.
// Latency: a word accepted at edge N is presented on im_we/im_wdata in the cycle after N.
// Backpressure: the FIFO absorbs a stalled IM. req_ready drops while it is full, with no pass-through.
// Optional feature: define INSTR_ENC_CHECK_EN to drop illegal kinds and raise the sticky err flag.
module instr_encoder #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 4
) (
   input logic            clk,
   input logic            rst,
   instr_encoder_if.slave bus
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q;
   logic              busy_q;
   logic              done_q;
   logic [ADDR_W-1:0] addr_q;
   logic              wrapped_q;

   logic [31:0]       mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q;
   logic [PW-1:0]     rd_ptr_q;
   logic [CW-1:0]     count_q;

   logic              full;
   logic              empty;
   logic              req_ready;
   logic              accept;
   logic              push;
   logic              pop;
   logic [31:0]       enc_word;

   assign full      = (count_q == DEPTH_C);
   assign empty     = (count_q == '0);
   // The ready and write-enable signals depend only on registered state.
   assign req_ready = (state_q == S_RUN) && !full;
   assign accept    = bus.req_valid && req_ready;
   assign pop       = !empty && bus.im_ready;

   // Encode the presented request into its machine word.
   always_comb begin
      enc_word = '0;
      case (bus.req_kind)
         4'd0:    enc_word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h20}; // ADD
         4'd1:    enc_word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h22}; // SUB
         4'd2:    enc_word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h21}; // ADDU
         4'd3:    enc_word = {6'h00, bus.req_rs, bus.req_rt, bus.req_rd, 5'd0, 6'h23}; // SUBU
         4'd4:    enc_word = {6'h0D, bus.req_rs, bus.req_rt, bus.req_imm};             // ORI
         4'd5:    enc_word = {6'h04, bus.req_rs, bus.req_rt, bus.req_imm};             // BEQ
         4'd6:    enc_word = {6'h05, bus.req_rs, bus.req_rt, bus.req_imm};             // BNE
         4'd7:    enc_word = {6'h23, bus.req_rs, bus.req_rt, bus.req_imm};             // LW
         4'd8:    enc_word = {6'h2B, bus.req_rs, bus.req_rt, bus.req_imm};             // SW
         4'd9:    enc_word = {6'h0F, 5'd0, bus.req_rt, bus.req_imm};                   // LUI, rs forced to 0
         4'd10:   enc_word = {6'h0A, bus.req_rs, bus.req_rt, bus.req_imm};             // SLTI
         default: enc_word = '0;                                                       // illegal: NOP
      endcase
   end

`ifdef INSTR_ENC_CHECK_EN
   logic kind_legal;
   logic err_q;

   assign kind_legal = (bus.req_kind <= 4'd10);
   assign push       = accept && kind_legal;
   assign bus.err    = err_q;

   // The sticky illegal-kind flag is cleared by a new program start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (state_q == S_IDLE && bus.start) begin
         err_q <= 1'b0;
      end else if (accept && !kind_legal) begin
         err_q <= 1'b1;
      end
   end
`else
   assign push    = accept;
   assign bus.err = 1'b0;
`endif

   // Control FSM. busy and done are registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               if (bus.seal) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (empty) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // The address counter loads on start and advances once per completed IM write.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q    <= '0;
         wrapped_q <= 1'b0;
      end else if (state_q == S_IDLE && bus.start) begin
         addr_q    <= bus.base;
         wrapped_q <= 1'b0;
      end else if (pop) begin
         addr_q <= addr_q + 1'b1;
         if (&addr_q) begin
            wrapped_q <= 1'b1;
         end
      end
   end

   // FIFO pointers and occupancy. A push and a pop in the same cycle leave the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage. Reset is not needed because the head is gated while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= enc_word;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.im_we     = !empty;
   assign bus.im_addr   = addr_q;
   assign bus.im_wdata  = empty ? 32'h0 : mem_q[rd_ptr_q];
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.wrapped   = wrapped_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder. Stimulus pushes the expected {addr, word} for each accepted request.
// A negedge monitor pops the scoreboard and compares on every IM write.
module tb_instr_encoder;

`ifdef INSTR_ENC_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   typedef struct packed {
      logic [9:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   done_cnt;
   exp_t sb_q[$];
   exp_t mon_e;
   logic [9:0] exp_addr;

   instr_encoder_if #(.ADDR_W(10)) bus ();

   instr_encoder #(.ADDR_W(10), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every IM write must match the oldest scoreboard entry.
   always @(negedge clk) begin
      if (bus.done) done_cnt++;
      if (!rst && bus.im_we && bus.im_ready) begin
         total++;
         if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write: got addr=%0d data=%h expected no write", bus.im_addr, bus.im_wdata);
         end else begin
            mon_e = sb_q.pop_front();
            if (bus.im_addr !== mon_e.addr || bus.im_wdata !== mon_e.data) begin
               bad++;
               $display("FAIL im_write: got addr=%0d data=%h expected addr=%0d data=%h",
                        bus.im_addr, bus.im_wdata, mon_e.addr, mon_e.data);
            end
         end
      end
   end

   task automatic pulse_start(input logic [9:0] b);
      bus.base  = b;
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      exp_addr  = b;
   endtask

   task automatic pulse_seal();
      bus.seal = 1'b1;
      @(posedge clk); #1;
      bus.seal = 1'b0;
   endtask

   task automatic send(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm,
                       input logic [31:0] word, input bit will_write);
      int n;
      n = 0;
      bus.req_valid = 1'b1;
      bus.req_kind  = k;
      bus.req_rs    = rs;
      bus.req_rt    = rt;
      bus.req_rd    = rd;
      bus.req_imm   = imm;
      @(negedge clk);
      while (!bus.req_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!bus.req_ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got req_ready=0 for kind %0d expected acceptance", k);
      end else if (will_write) begin
         sb_q.push_back({exp_addr, word});
         exp_addr = exp_addr + 10'd1;
      end
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.done && n < 200) begin
         n++;
         @(negedge clk);
      end
      total++;
      if (!bus.done) begin
         bad++;
         $display("FAIL %s: got no done pulse expected done=1", name);
      end
   endtask

   initial begin
      int d0;
      total = 0; bad = 0; done_cnt = 0; exp_addr = '0;
      rst = 1'b1;
      bus.start = 0; bus.base = '0; bus.seal = 0; bus.req_valid = 0;
      bus.req_kind = '0; bus.req_rs = '0; bus.req_rt = '0; bus.req_rd = '0; bus.req_imm = '0;
      bus.im_ready = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_im_we", bus.im_we, 0);
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_addr", bus.im_addr, 0);
      chk("rst_wrapped", bus.wrapped, 0);
      chk("rst_err", bus.err, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // seal while idle is ignored
      pulse_seal();
      @(negedge clk);
      chk("seal_idle_busy", bus.busy, 0);
      @(posedge clk); #1;

      // program 1: encodings and first-word latency
      bus.im_ready = 1'b1;
      pulse_start(10'd0);
      @(negedge clk);
      chk("run_busy", bus.busy, 1);
      chk("run_req_ready", bus.req_ready, 1);
      @(posedge clk); #1;
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h00221820, 1);
      @(negedge clk);
      chk("lat_im_we", bus.im_we, 1);
      chk("lat_addr", bus.im_addr, 0);
      chk("lat_wdata", bus.im_wdata, 32'h00221820);
      @(posedge clk); #1;
      send(4'd4, 5'd0, 5'd8, 5'd0, 16'h1234, 32'h34081234, 1);
      send(4'd9, 5'd5, 5'd1, 5'd7, 16'h8000, 32'h3C018000, 1);
      send(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 32'h00853022, 1);
      send(4'd5, 5'd1, 5'd2, 5'd0, 16'hFFFF, 32'h1022FFFF, 1);
      send(4'd7, 5'd29, 5'd8, 5'd0, 16'h0004, 32'h8FA80004, 1);
      send(4'd8, 5'd29, 5'd8, 5'd0, 16'h0004, 32'hAFA80004, 1);
      pulse_seal();
      wait_done("p1_done");
      chk("p1_drained", sb_q.size(), 0);
      @(negedge clk);
      chk("p1_busy_fall", bus.busy, 0);
      @(posedge clk); #1;

      // program 2: backpressure with DEPTH=4
      bus.im_ready = 1'b0;
      pulse_start(10'd0);
      send(4'd2, 5'd1, 5'd1, 5'd1, 16'h0, 32'h00210821, 1);
      send(4'd3, 5'd2, 5'd2, 5'd2, 16'h0, 32'h00421023, 1);
      send(4'd6, 5'd3, 5'd4, 5'd0, 16'h0010, 32'h14640010, 1);
      send(4'd10, 5'd5, 5'd6, 5'd0, 16'h7FFF, 32'h28A67FFF, 1);
      @(negedge clk);
      chk("full_req_ready", bus.req_ready, 0);
      chk("full_im_we", bus.im_we, 1);
      @(posedge clk); #1;
      bus.im_ready = 1'b1;
      send(4'd0, 5'd7, 5'd8, 5'd9, 16'h0, 32'h00E84820, 1);
      pulse_seal();
      wait_done("p2_done");
      chk("p2_drained", sb_q.size(), 0);
      @(posedge clk); #1;

      // program 3: address wrap
      d0 = done_cnt;
      pulse_start(10'd1023);
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h00221820, 1);
      send(4'd4, 5'd0, 5'd8, 5'd0, 16'h1234, 32'h34081234, 1);
      pulse_seal();
      wait_done("p3_done");
      repeat (3) @(negedge clk);
      chk("p3_drained", sb_q.size(), 0);
      chk("p3_wrapped", bus.wrapped, 1);
      chk("p3_done_once", done_cnt - d0, 1);
      chk("p3_busy_fall", bus.busy, 0);
      @(posedge clk); #1;

      // program 4: illegal kind
      pulse_start(10'd8);
      @(negedge clk);
      chk("p4_wrapped_clr", bus.wrapped, 0);
      @(posedge clk); #1;
      send(4'd15, 5'd1, 5'd2, 5'd3, 16'hABCD, 32'h00000000, !CHECK_EN);
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h00221820, 1);
      pulse_seal();
      wait_done("p4_done");
      chk("p4_err", bus.err, CHECK_EN ? 32'd1 : 32'd0);
      chk("p4_drained", sb_q.size(), 0);
      @(posedge clk); #1;

      // program 5: reset mid-program discards queued words
      bus.im_ready = 1'b0;
      pulse_start(10'd5);
      send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 0);
      send(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 0);
      send(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 32'h0, 0);
      @(negedge clk);
      chk("p5_queued_we", bus.im_we, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("p5_rst_im_we", bus.im_we, 0);
      chk("p5_rst_busy", bus.busy, 0);
      chk("p5_rst_addr", bus.im_addr, 0);
      chk("p5_rst_req_ready", bus.req_ready, 0);
      sb_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      bus.im_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("p5_no_write", bus.im_we, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
